prefetch_scheduler: RTL and testbench

PREFETCH_SCHEDULER -- requirements
Module: prefetch_scheduler

---
 rtl/pf_sched_pkg.sv | 6 +
 rtl/pf_sched_fifo.sv | 61 ++++++
 rtl/prefetch_scheduler.sv | 91 +++++++++
 tb/tb_prefetch_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pf_sched_pkg.sv
// pf_sched_pkg: shared widths and FSM state type for the prefetch scheduler
package pf_sched_pkg;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} stateT;
endpackage

// File: rtl/pf_sched_fifo.sv
// pf_sched_fifo: prefetch queue with per-slot valid bits, address match and invalidate
module pf_sched_fifo
    import pf_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic              pop,
    input  logic              inv,
    input  logic [ADDR_W-1:0] invAddr,
    input  logic [ADDR_W-1:0] matchAddr,
    output logic              full,
    output logic              empty,
    output logic              headValid,
    output logic [ADDR_W-1:0] headAddr,
    output logic              matchHit
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wrPtr, rdPtr;
    logic [DEPTH-1:0]  slotValid;
    logic [ADDR_W-1:0] slotAddr [DEPTH];

    assign empty     = wrPtr == rdPtr;
    assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign headValid = slotValid[rdPtr[AW-1:0]];
    assign headAddr  = slotAddr[rdPtr[AW-1:0]];

    // any live entry holding the queried address
    always_comb begin
        matchHit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (slotValid[i] && slotAddr[i] == matchAddr) matchHit = 1'b1;
    end

    // pointers and slots; a push into the slot freed by a same-cycle pop wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            slotValid <= '0;
            for (int i = 0; i < DEPTH; i++) slotAddr[i] <= '0;
        end else begin
            if (inv)
                for (int i = 0; i < DEPTH; i++)
                    if (slotAddr[i] == invAddr) slotValid[i] <= 1'b0;
            if (pop) begin
                slotValid[rdPtr[AW-1:0]] <= 1'b0;
                rdPtr <= rdPtr + 1'b1;
            end
            if (push) begin
                slotValid[wrPtr[AW-1:0]] <= 1'b1;
                slotAddr[wrPtr[AW-1:0]]  <= pushAddr;
                wrPtr <= wrPtr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prefetch_scheduler.sv
// prefetch_scheduler: arbitrates demand and queued prefetch requests onto one memory port
module prefetch_scheduler
    import pf_sched_pkg::*;
#(
    parameter int PF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dem_valid,
    input  logic [ADDR_W-1:0] dem_addr,
    output logic              dem_ready,
    input  logic              pf_valid,
    input  logic [ADDR_W-1:0] pf_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_is_pf,
    input  logic              mem_ack,
    input  logic              mem_done,
    output logic              busy,
    output logic [CNT_W-1:0]  pf_drop_cnt,
    output logic [CNT_W-1:0]  pf_issue_cnt
);
    stateT             state, stateNext;
    logic [ADDR_W-1:0] reqAddr, reqAddrNext, headAddr;
    logic              isPf, isPfNext, pop, push, dup, qFull, qEmpty, headValid, camHit;

    assign dem_ready = state == IDLE && dem_valid;
    assign dup       = camHit || (state != IDLE && pf_addr == reqAddr) || (dem_valid && pf_addr == dem_addr);
    assign push      = pf_valid && !dup && (!qFull || pop);
    assign mem_req   = state == REQ;
    assign mem_addr  = reqAddr;
    assign mem_is_pf = isPf;
    assign busy      = state != IDLE;

    pf_sched_fifo #(.DEPTH(PF_DEPTH)) fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pushAddr(pf_addr), .pop(pop),
        .inv(dem_ready), .invAddr(dem_addr), .matchAddr(pf_addr),
        .full(qFull), .empty(qEmpty), .headValid(headValid), .headAddr(headAddr), .matchHit(camHit)
    );

    // state and the latched request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            reqAddr <= '0;
            isPf    <= 1'b0;
        end else begin
            state   <= stateNext;
            reqAddr <= reqAddrNext;
            isPf    <= isPfNext;
        end
    end

    // demand beats prefetch in IDLE; invalidated heads are popped and dropped
    always_comb begin
        stateNext   = state;
        reqAddrNext = reqAddr;
        isPfNext    = isPf;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (dem_valid) begin
                    stateNext   = REQ;
                    reqAddrNext = dem_addr;
                    isPfNext    = 1'b0;
                end else if (!qEmpty) begin
                    pop = 1'b1;
                    if (headValid) begin
                        stateNext   = REQ;
                        reqAddrNext = headAddr;
                        isPfNext    = 1'b1;
                    end
                end
            end
            REQ:     stateNext = mem_ack ? WAIT : REQ;
            WAIT:    stateNext = mem_done ? IDLE : WAIT;
            default: stateNext = IDLE;
        endcase
    end

    // drop count saturates, issue count wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_drop_cnt  <= '0;
            pf_issue_cnt <= '0;
        end else begin
            if (pf_valid && !dup && qFull && !pop && pf_drop_cnt != '1) pf_drop_cnt <= pf_drop_cnt + 1'b1;
            if (state == REQ && mem_ack && isPf) pf_issue_cnt <= pf_issue_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_prefetch_scheduler.sv
// tb_prefetch_scheduler: directed scenario checks for prefetch_scheduler
module tb_prefetch_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dem_valid = 1'b0, pf_valid = 1'b0, mem_ack = 1'b0, mem_done = 1'b0;
    logic [15:0] dem_addr = '0, pf_addr = '0;
    logic        dem_ready, mem_req, mem_is_pf, busy;
    logic [15:0] mem_addr;
    logic [7:0]  pf_drop_cnt, pf_issue_cnt;
    int          passCnt = 0, totalCnt = 0;
    bit          got;

    prefetch_scheduler #(.PF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .dem_valid(dem_valid), .dem_addr(dem_addr), .dem_ready(dem_ready),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_is_pf(mem_is_pf), .mem_ack(mem_ack), .mem_done(mem_done), .busy(busy),
        .pf_drop_cnt(pf_drop_cnt), .pf_issue_cnt(pf_issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++)
            if (mem_req) ok = 1'b1;
            else tick();
    endtask

    task automatic serve;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
    endtask

    task automatic test_reset;
        #12 rst_n = 1'b1;
        tick();
        totalCnt++; if ({mem_req, mem_is_pf, busy, dem_ready} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {mem_req, mem_is_pf, busy, dem_ready}); else passCnt++;
        totalCnt++; if (mem_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", mem_addr); else passCnt++;
        totalCnt++; if ({pf_drop_cnt, pf_issue_cnt} !== 16'h0) $display("FAIL reset_cnts got %h want 0000", {pf_drop_cnt, pf_issue_cnt}); else passCnt++;
    endtask

    task automatic test_pf_single;
        pf_valid = 1'b1; pf_addr = 16'h0100;
        tick();
        pf_valid = 1'b0;
        wait_req(4, got);
        totalCnt++; if (!got) $display("FAIL s1_req_timeout got 0 want 1"); else passCnt++;
        totalCnt++; if ({mem_addr, mem_is_pf} !== {16'h0100, 1'b1}) $display("FAIL s1_req got %h/%b want 0100/1", mem_addr, mem_is_pf); else passCnt++;
        tick();
        totalCnt++; if ({mem_req, mem_addr} !== {1'b1, 16'h0100}) $display("FAIL s1_hold got %b/%h want 1/0100", mem_req, mem_addr); else passCnt++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        totalCnt++; if ({mem_req, busy, pf_issue_cnt} !== {1'b0, 1'b1, 8'd1}) $display("FAIL s1_wait got %b/%b/%0d want 0/1/1", mem_req, busy, pf_issue_cnt); else passCnt++;
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        totalCnt++; if (busy !== 1'b0) $display("FAIL s1_idle got %b want 0", busy); else passCnt++;
    endtask

    task automatic test_dem_priority;
        dem_valid = 1'b1; dem_addr = 16'h0200; pf_valid = 1'b1; pf_addr = 16'h0300;
        #1;
        totalCnt++; if (dem_ready !== 1'b1) $display("FAIL s2_dem_ready got %b want 1", dem_ready); else passCnt++;
        tick();
        dem_valid = 1'b0; pf_valid = 1'b0;
        totalCnt++; if ({mem_req, mem_addr, mem_is_pf} !== {1'b1, 16'h0200, 1'b0}) $display("FAIL s2_dem got %b/%h/%b want 1/0200/0", mem_req, mem_addr, mem_is_pf); else passCnt++;
        serve();
        totalCnt++; if (mem_req !== 1'b0) $display("FAIL s2_grant_gap got %b want 0", mem_req); else passCnt++;
        tick();
        totalCnt++; if ({mem_req, mem_addr, mem_is_pf} !== {1'b1, 16'h0300, 1'b1}) $display("FAIL s2_pf got %b/%h/%b want 1/0300/1", mem_req, mem_addr, mem_is_pf); else passCnt++;
        serve();
        totalCnt++; if (pf_issue_cnt !== 8'd2) $display("FAIL s2_issue got %0d want 2", pf_issue_cnt); else passCnt++;
    endtask

    task automatic test_full_and_dup;
        logic [15:0] pushes [6] = '{16'h10, 16'h20, 16'h30, 16'h40, 16'h50, 16'h20};
        logic [15:0] drains [4] = '{16'h10, 16'h20, 16'h30, 16'h40};
        dem_valid = 1'b1; dem_addr = 16'h0999;
        tick();
        dem_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pf_valid = 1'b1; pf_addr = pushes[i];
            tick();
            if (i == 4) begin
                totalCnt++; if (pf_drop_cnt !== 8'd1) $display("FAIL s3_drop got %0d want 1", pf_drop_cnt); else passCnt++;
            end
        end
        pf_valid = 1'b0;
        totalCnt++; if (pf_drop_cnt !== 8'd1) $display("FAIL s3_dup got %0d want 1", pf_drop_cnt); else passCnt++;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_req(4, got);
            totalCnt++; if (!got || mem_addr !== drains[i] || mem_is_pf !== 1'b1) $display("FAIL s3_drain%0d got %b/%h want 1/%h", i, got, mem_addr, drains[i]); else passCnt++;
            serve();
        end
        totalCnt++; if (pf_issue_cnt !== 8'd6) $display("FAIL s3_issue got %0d want 6", pf_issue_cnt); else passCnt++;
    endtask

    task automatic test_invalidate;
        dem_valid = 1'b1; dem_addr = 16'h0777;
        tick();
        dem_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0010;
        tick();
        pf_addr = 16'h0020;
        tick();
        pf_valid = 1'b0;
        dem_valid = 1'b1; dem_addr = 16'h0020; mem_done = 1'b1;
        #1;
        totalCnt++; if (dem_ready !== 1'b0) $display("FAIL s4_ready_in_wait got %b want 0", dem_ready); else passCnt++;
        tick();
        mem_done = 1'b0;
        totalCnt++; if (dem_ready !== 1'b1) $display("FAIL s4_ready_idle got %b want 1", dem_ready); else passCnt++;
        tick();
        dem_valid = 1'b0;
        totalCnt++; if ({mem_req, mem_addr, mem_is_pf} !== {1'b1, 16'h0020, 1'b0}) $display("FAIL s4_dem got %b/%h/%b want 1/0020/0", mem_req, mem_addr, mem_is_pf); else passCnt++;
        serve();
        wait_req(4, got);
        totalCnt++; if (!got || mem_addr !== 16'h0010 || mem_is_pf !== 1'b1) $display("FAIL s4_pf got %b/%h/%b want 1/0010/1", got, mem_addr, mem_is_pf); else passCnt++;
        serve();
        repeat (3) tick();
        totalCnt++; if ({mem_req, busy, pf_issue_cnt} !== {1'b0, 1'b0, 8'd7}) $display("FAIL s4_no_stale got %b/%b/%0d want 0/0/7", mem_req, busy, pf_issue_cnt); else passCnt++;
    endtask

    task automatic test_reset_mid_req;
        dem_valid = 1'b1; dem_addr = 16'h0400;
        tick();
        dem_valid = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0500;
        tick();
        pf_valid = 1'b0;
        totalCnt++; if ({mem_req, mem_addr} !== {1'b1, 16'h0400}) $display("FAIL s5_req got %b/%h want 1/0400", mem_req, mem_addr); else passCnt++;
        #2 rst_n = 1'b0;
        #1;
        totalCnt++; if ({mem_req, mem_is_pf, busy, mem_addr} !== 19'h0) $display("FAIL s5_async got %b/%b/%b/%h want 0/0/0/0000", mem_req, mem_is_pf, busy, mem_addr); else passCnt++;
        totalCnt++; if ({pf_drop_cnt, pf_issue_cnt} !== 16'h0) $display("FAIL s5_cnts got %h want 0000", {pf_drop_cnt, pf_issue_cnt}); else passCnt++;
        tick();
        #2 rst_n = 1'b1;
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        repeat (2) tick();
        totalCnt++; if ({mem_req, busy} !== 2'b00) $display("FAIL s5_late_done got %b/%b want 0/0", mem_req, busy); else passCnt++;
    endtask

    task automatic test_drop_saturate;
        dem_valid = 1'b1; dem_addr = 16'h0001;
        tick();
        dem_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pf_valid = 1'b1; pf_addr = 16'hA000 + 16'(i);
            tick();
        end
        for (int i = 0; i < 255; i++) begin
            pf_addr = 16'hB000 + 16'(i);
            tick();
            if (i == 253) begin
                totalCnt++; if (pf_drop_cnt !== 8'd254) $display("FAIL s6_pre got %0d want 254", pf_drop_cnt); else passCnt++;
            end
        end
        totalCnt++; if (pf_drop_cnt !== 8'd255) $display("FAIL s6_255 got %0d want 255", pf_drop_cnt); else passCnt++;
        pf_addr = 16'hC000;
        tick();
        pf_valid = 1'b0;
        totalCnt++; if (pf_drop_cnt !== 8'd255) $display("FAIL s6_sat got %0d want 255", pf_drop_cnt); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_pf_single();
        test_dem_priority();
        test_full_and_dup();
        test_invalidate();
        test_reset_mid_req();
        test_drop_saturate();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
